// File: rtl/mirfak_lsu_pkg.sv
// mirfak_lsu_pkg
// Shared definitions for the Mirfak load/store unit.
//   - MEM_SIZE_* : encodings of the size_i access-size field
//   - lsu_state_e: LSU sequencer states (also exported on dbg_state_o)
//   - lane_offset: byte offset within the word actually used for lane
//                  select and load shift
//   - misaligned_access: natural-alignment test for an access
package mirfak_lsu_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_BUS  = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_e;

    // Address bits below the access size are dropped, so half and word
    // accesses always land on their natural lanes. The reserved size
    // encoding behaves as a word.
    function automatic logic [1:0] lane_offset(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        case (size)
            MEM_SIZE_BYTE: return addr_lo;
            MEM_SIZE_HALF: return {addr_lo[1], 1'b0};
            default:       return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned_access(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        case (size)
            MEM_SIZE_BYTE: return 1'b0;
            MEM_SIZE_HALF: return addr_lo[0];
            default:       return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mirfak_lsu_fmt.sv
// mirfak_lsu_fmt
// Purely combinational data formatting for the LSU.
//   Store side: st_size/st_off/st_wdata -> st_sel (byte lanes), st_data
//               (store data replicated across all lanes).
//   Load side : ld_dat shifted down by ld_off bytes, then sign- or
//               zero-extended per ld_size/ld_unsigned -> ld_data.
//               Stores (ld_we=1) produce zero.
module mirfak_lsu_fmt
    import mirfak_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_sel,
    output logic [31:0] st_data,
    input  logic        ld_we,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_dat,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_sel  = 4'b1111;
        st_data = st_wdata;
        case (st_size)
            MEM_SIZE_BYTE: begin
                st_sel  = 4'b0001 << st_off;
                st_data = {4{st_wdata[7:0]}};
            end
            MEM_SIZE_HALF: begin
                st_sel  = 4'b0011 << st_off;
                st_data = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = ld_dat >> {ld_off, 3'b000};
        ld_data = shifted;
        case (ld_size)
            MEM_SIZE_BYTE: ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
            MEM_SIZE_HALF: ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
        if (ld_we) begin
            ld_data = 32'h0;
        end
    end

endmodule

// File: rtl/mirfak_lsu.sv
// mirfak_lsu
// Load/store unit: runs one Wishbone B4 classic cycle per memory
// instruction, stalls the pipeline until it completes and returns
// formatted load data.
//   Pipeline side : valid_i, kill_i, we_i, size_i, unsigned_i, addr_i,
//                   wdata_i -> rdata_o, done_o, stall_o
//   Exceptions    : misaligned_o, bus_error_o, fault_addr_o
//   Wishbone      : dwbm_* master request / response
//   Debug         : dbg_state_o (current sequencer state)
// Build option: define MIRFAK_LSU_MISALIGN_CHECK_EN to raise misaligned_o
// on unaligned half/word accesses; otherwise the low address bits are
// ignored and every valid, unkilled request runs a bus cycle.
//
// Handshake: a request is taken in IDLE when valid_i=1 and kill_i=0 (and
// it is not misaligned); stall_o stays high until the cycle in which
// done_o pulses. Wishbone: cyc/stb stay high and all request fields stay
// stable until ack or err is seen; err wins over ack.
module mirfak_lsu
    import mirfak_lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        kill_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic        bus_error_o,
    output logic [31:0] fault_addr_o,
    output logic [31:0] dwbm_addr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_we_o,
    output logic        dwbm_cyc_o,
    output logic        dwbm_stb_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    input  logic        dwbm_err_i,
    output logic [1:0]  dbg_state_o
);

    lsu_state_e  state;
    logic [1:0]  req_off;
    logic        mis;
    logic        start;
    logic        bus_end;
    logic [31:0] fault_addr_q;
    logic [1:0]  ld_size_q;
    logic [1:0]  ld_off_q;
    logic        ld_unsigned_q;
    logic [3:0]  st_sel;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    assign req_off = lane_offset(size_i, addr_i[1:0]);

`ifdef MIRFAK_LSU_MISALIGN_CHECK_EN
    assign mis = (state == LSU_IDLE) & valid_i & ~kill_i &
                 misaligned_access(size_i, addr_i[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign start        = (state == LSU_IDLE) & valid_i & ~kill_i & ~mis;
    assign stall_o      = start | (state == LSU_BUS);
    assign misaligned_o = mis;
    // A misaligned access never reaches the bus, so its address is reported
    // straight from the input in the same cycle.
    assign fault_addr_o = mis ? addr_i : fault_addr_q;
    assign bus_end      = dwbm_cyc_o & dwbm_stb_o & (dwbm_ack_i | dwbm_err_i);
    assign dbg_state_o  = state;

    mirfak_lsu_fmt u_fmt (
        .st_size     (size_i),
        .st_off      (req_off),
        .st_wdata    (wdata_i),
        .st_sel      (st_sel),
        .st_data     (st_data),
        .ld_we       (dwbm_we_o),
        .ld_size     (ld_size_q),
        .ld_off      (ld_off_q),
        .ld_unsigned (ld_unsigned_q),
        .ld_dat      (dwbm_dat_i),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= LSU_IDLE;
            dwbm_addr_o   <= 32'h0;
            dwbm_dat_o    <= 32'h0;
            dwbm_sel_o    <= 4'h0;
            dwbm_we_o     <= 1'b0;
            dwbm_cyc_o    <= 1'b0;
            dwbm_stb_o    <= 1'b0;
            rdata_o       <= 32'h0;
            done_o        <= 1'b0;
            bus_error_o   <= 1'b0;
            fault_addr_q  <= 32'h0;
            ld_size_q     <= MEM_SIZE_BYTE;
            ld_off_q      <= 2'b00;
            ld_unsigned_q <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (start) begin
                        state         <= LSU_BUS;
                        dwbm_addr_o   <= {addr_i[31:2], 2'b00};
                        dwbm_dat_o    <= st_data;
                        dwbm_sel_o    <= st_sel;
                        dwbm_we_o     <= we_i;
                        dwbm_cyc_o    <= 1'b1;
                        dwbm_stb_o    <= 1'b1;
                        fault_addr_q  <= addr_i;
                        ld_size_q     <= size_i;
                        ld_off_q      <= req_off;
                        ld_unsigned_q <= unsigned_i;
                    end
                end
                LSU_BUS: begin
                    if (bus_end) begin
                        state       <= LSU_DONE;
                        dwbm_cyc_o  <= 1'b0;
                        dwbm_stb_o  <= 1'b0;
                        rdata_o     <= dwbm_err_i ? 32'h0 : ld_data;
                        bus_error_o <= dwbm_err_i;
                        done_o      <= 1'b1;
                    end
                end
                LSU_DONE: begin
                    state       <= LSU_IDLE;
                    done_o      <= 1'b0;
                    bus_error_o <= 1'b0;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mirfak_lsu.sv
module tb_mirfak_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        stall_o;
    logic        misaligned_o;
    logic        bus_error_o;
    logic [31:0] fault_addr_o;
    logic [31:0] dwbm_addr_o;
    logic [31:0] dwbm_dat_o;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_we_o;
    logic        dwbm_cyc_o;
    logic        dwbm_stb_o;
    logic [31:0] dwbm_dat_i = 32'h0;
    logic        dwbm_ack_i = 1'b0;
    logic        dwbm_err_i = 1'b0;
    logic [1:0]  dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

`ifdef MIRFAK_LSU_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    mirfak_lsu dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .kill_i       (kill_i),
        .we_i         (we_i),
        .size_i       (size_i),
        .unsigned_i   (unsigned_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .done_o       (done_o),
        .stall_o      (stall_o),
        .misaligned_o (misaligned_o),
        .bus_error_o  (bus_error_o),
        .fault_addr_o (fault_addr_o),
        .dwbm_addr_o  (dwbm_addr_o),
        .dwbm_dat_o   (dwbm_dat_o),
        .dwbm_sel_o   (dwbm_sel_o),
        .dwbm_we_o    (dwbm_we_o),
        .dwbm_cyc_o   (dwbm_cyc_o),
        .dwbm_stb_o   (dwbm_stb_o),
        .dwbm_dat_i   (dwbm_dat_i),
        .dwbm_ack_i   (dwbm_ack_i),
        .dwbm_err_i   (dwbm_err_i),
        .dbg_state_o  (dbg_state_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // reference model helpers
    function automatic int nbytes(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    function automatic int lane_of(input logic [1:0] size, input logic [31:0] addr);
        int n;
        n = nbytes(size);
        return ((addr % 4) / n) * n;
    endfunction

    function automatic logic [31:0] model_rdata(input logic we, input logic [1:0] size,
                                                input logic uns, input logic [31:0] addr,
                                                input logic [31:0] rd);
        int n, off;
        logic [31:0] mask, val;
        if (we) return 32'h0;
        n    = nbytes(size);
        off  = lane_of(size, addr);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        val  = (rd >> (8 * off)) & mask;
        if (!uns && n < 4 && val[8 * n - 1]) val = val | ~mask;
        return val;
    endfunction

    // driver: one full access, checked cycle by cycle
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int delay,
                             input logic err, input logic kill_mid);
        int n, off;
        logic mis;
        logic [3:0] exp_sel;
        logic [31:0] exp_dat, got_exp;
        n   = nbytes(size);
        off = lane_of(size, addr);
        mis = CHK && ((addr % n) != 0);
        exp_sel = 4'(((1 << n) - 1) << off);
        if (n == 1)      exp_dat = (wd & 32'hFF) * 32'h0101_0101;
        else if (n == 2) exp_dat = (wd & 32'hFFFF) * 32'h0001_0001;
        else             exp_dat = wd;

        @(negedge clk_i);
        valid_i = 1'b1; kill_i = 1'b0; we_i = we; size_i = size;
        unsigned_i = uns; addr_i = addr; wdata_i = wd;
        #1;
        check("mis_c0", misaligned_o, mis);
        check("stall_c0", stall_o, !mis);
        check("done_c0", done_o, 1'b0);
        check("cyc_c0", dwbm_cyc_o, 1'b0);
        if (mis) begin
            check("fault_mis", fault_addr_o, addr);
            @(negedge clk_i);
            valid_i = 1'b0;
            #1;
            check("cyc_after_mis", dwbm_cyc_o, 1'b0);
            check("done_after_mis", done_o, 1'b0);
            return;
        end
        exp_q.push_back(err ? 32'h0 : model_rdata(we, size, uns, addr, rd));

        for (int c = 1; c <= delay + 1; c++) begin
            @(negedge clk_i);
            kill_i     = kill_mid;
            dwbm_dat_i = rd;
            dwbm_ack_i = (c == delay + 1) && !err ? 1'b1 : ($urandom_range(0, 1) == 1 && err && c == delay + 1);
            dwbm_err_i = (c == delay + 1) && err;
            #1;
            check("cyc", dwbm_cyc_o, 1'b1);
            check("stb", dwbm_stb_o, 1'b1);
            check("addr", dwbm_addr_o, {addr[31:2], 2'b00});
            check("sel", dwbm_sel_o, exp_sel);
            check("we", dwbm_we_o, we);
            if (we) check("dat", dwbm_dat_o, exp_dat);
            check("stall_bus", stall_o, 1'b1);
            check("done_bus", done_o, 1'b0);
        end

        @(negedge clk_i);
        dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0; valid_i = 1'b0; kill_i = 1'b0;
        dwbm_dat_i = $urandom;
        #1;
        got_exp = exp_q.pop_front();
        check("done", done_o, 1'b1);
        check("stall_done", stall_o, 1'b0);
        check("cyc_done", dwbm_cyc_o, 1'b0);
        check("stb_done", dwbm_stb_o, 1'b0);
        check("bus_error", bus_error_o, err);
        check("fault_addr", fault_addr_o, addr);
        check("rdata", rdata_o, got_exp);
    endtask

    initial begin
        // reset
        #1;
        check("rst_cyc", dwbm_cyc_o, 1'b0);
        check("rst_stb", dwbm_stb_o, 1'b0);
        check("rst_we", dwbm_we_o, 1'b0);
        check("rst_sel", dwbm_sel_o, 4'h0);
        check("rst_addr", dwbm_addr_o, 32'h0);
        check("rst_dat", dwbm_dat_o, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_done", done_o, 1'b0);
        check("rst_berr", bus_error_o, 1'b0);
        check("rst_fault", fault_addr_o, 32'h0);
        check("rst_stall", stall_o, 1'b0);
        check("rst_mis", misaligned_o, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // directed cases
        do_access(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FF_FF12, 0, 1'b0, 1'b0);
        check("lb_value", rdata_o, 32'hFFFF_FF80);
        do_access(1'b1, 2'd1, 1'b0, 32'h2002, 32'hABCD_1234, 32'h0, 3, 1'b0, 1'b0);
        do_access(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h1122_3344, 1, 1'b0, 1'b0);
        do_access(1'b0, 2'd1, 1'b1, 32'h4000, 32'h0, 32'hFFFF_FFFF, 0, 1'b1, 1'b0);
        do_access(1'b0, 2'd2, 1'b0, 32'h4444, 32'h0, 32'hCAFE_F00D, 2, 1'b0, 1'b1);

        // killed request in IDLE: no bus cycle
        @(negedge clk_i);
        valid_i = 1'b1; kill_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h3001;
        #1;
        check("kill_stall", stall_o, 1'b0);
        check("kill_mis", misaligned_o, 1'b0);
        @(negedge clk_i);
        valid_i = 1'b0; kill_i = 1'b0;
        #1;
        check("kill_cyc", dwbm_cyc_o, 1'b0);

        // stray ack in IDLE is ignored
        @(negedge clk_i);
        dwbm_ack_i = 1'b1;
        @(negedge clk_i);
        dwbm_ack_i = 1'b0;
        #1;
        check("stray_done", done_o, 1'b0);
        check("stray_cyc", dwbm_cyc_o, 1'b0);

        // reset while a bus cycle is open
        @(negedge clk_i);
        valid_i = 1'b1; kill_i = 1'b0; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h5000;
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        check("rstbus_cyc_before", dwbm_cyc_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("rstbus_cyc", dwbm_cyc_o, 1'b0);
        check("rstbus_stb", dwbm_stb_o, 1'b0);
        check("rstbus_done", done_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check("rstbus_idle_done", done_o, 1'b0);
        check("rstbus_idle_cyc", dwbm_cyc_o, 1'b0);
        do_access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF, 0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
